channel_supervisor: RTL and testbench



---
 rtl/channel_supervisor_pkg.sv | 29 ++
 rtl/channel_supervisor_lane.sv | 175 +++++++++++++++++
 rtl/channel_supervisor.sv | 82 ++++++++
 tb/tb_channel_supervisor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/channel_supervisor_pkg.sv
// Shared types for channel_supervisor: channel state, LED mode and timer sizing.
package channel_supervisor_pkg;

  typedef enum logic [2:0] {
    CH_ABSENT       = 3'd0,
    CH_DEBOUNCE_IN  = 3'd1,
    CH_RESETTING    = 3'd2,
    CH_PRESENT      = 3'd3,
    CH_FAULT        = 3'd4,
    CH_DEBOUNCE_OUT = 3'd5
  } ch_state_e;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_SLOW  = 2'd1,
    LED_SOLID = 2'd2,
    LED_FAST  = 2'd3
  } led_mode_e;

  // The extra bit keeps the largest threshold comfortably below saturation.
  function automatic int timer_width(input int deb, input int hold, input int run_to);
    int m;
    m = deb;
    if (hold > m) m = hold;
    if (run_to > m) m = run_to;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/channel_supervisor_lane.sv
// One channel: presence synchroniser, supervision FSM, shared timer, registered outputs.
// Optional CHANNEL_SUPERVISOR_RETRY_EN: a persisting FAULT re-runs the module reset sequence.
module channel_supervisor_lane
  import channel_supervisor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 2_000_000,
  parameter int RESET_HOLD_CYCLES  = 20_000_000,
  parameter int RUN_TIMEOUT_CYCLES = 400_000_000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic modprsl_i,
  input  logic run_i,
  input  logic slow_phase_i,
  input  logic fast_phase_i,
  output logic module_resetl_o,
  output logic hpd_o,
  output logic fault_o,
  output logic led_o
);

  localparam int TW = timer_width(DEBOUNCE_CYCLES, RESET_HOLD_CYCLES, RUN_TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(RESET_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RUN_LAST  = TW'(RUN_TIMEOUT_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          present_s;
  ch_state_e     state_q, state_d;
  ch_state_e     ret_q, ret_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc_s;
  logic          mrl_q, mrl_d, hpd_q, hpd_d, fault_q, fault_d, led_q, led_d;
  logic          ret_up_s;
  led_mode_e     led_mode_s;

  assign present_s   = ~sync2_q;
  assign timer_inc_s = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

  // Next-state logic; every transition clears the timer.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    timer_d = timer_inc_s;
    case (state_q)
      CH_ABSENT: begin
        timer_d = '0;
        if (present_s) state_d = CH_DEBOUNCE_IN;
        else           state_d = CH_ABSENT;
      end
      CH_DEBOUNCE_IN: begin
        if (!present_s) begin
          state_d = CH_ABSENT;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = CH_RESETTING;
          timer_d = '0;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      CH_RESETTING: begin
        if (!present_s) begin
          state_d = CH_DEBOUNCE_OUT;
          ret_d   = CH_RESETTING;
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          state_d = CH_PRESENT;
          timer_d = '0;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      CH_PRESENT: begin
        if (!present_s) begin
          state_d = CH_DEBOUNCE_OUT;
          ret_d   = CH_PRESENT;
          timer_d = '0;
        end else if (run_i) begin
          timer_d = '0;
        end else if (timer_q == RUN_LAST) begin
          state_d = CH_FAULT;
          timer_d = '0;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      CH_FAULT: begin
        if (!present_s) begin
          state_d = CH_DEBOUNCE_OUT;
          ret_d   = CH_FAULT;
          timer_d = '0;
        end else if (run_i) begin
          state_d = CH_PRESENT;
          timer_d = '0;
`ifdef CHANNEL_SUPERVISOR_RETRY_EN
        end else if (timer_q == RUN_LAST) begin
          state_d = CH_RESETTING;
          timer_d = '0;
`endif
        end else begin
          timer_d = timer_inc_s;
        end
      end
      CH_DEBOUNCE_OUT: begin
        if (present_s) begin
          state_d = ret_q;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = CH_ABSENT;
          timer_d = '0;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      default: begin
        state_d = CH_ABSENT;
        ret_d   = CH_ABSENT;
        timer_d = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs change on the transition edge.
  always_comb begin
    ret_up_s = (ret_d == CH_PRESENT) || (ret_d == CH_FAULT);
    mrl_d    = (state_d == CH_PRESENT) || (state_d == CH_FAULT) ||
               ((state_d == CH_DEBOUNCE_OUT) && ret_up_s);
    hpd_d    = mrl_d;
    fault_d  = (state_d == CH_FAULT);
    case (state_d)
      CH_RESETTING: led_mode_s = LED_SLOW;
      CH_PRESENT:   led_mode_s = run_i ? LED_SOLID : LED_SLOW;
      CH_FAULT:     led_mode_s = LED_FAST;
      default:      led_mode_s = LED_OFF;
    endcase
    case (led_mode_s)
      LED_SLOW:  led_d = ~slow_phase_i;
      LED_SOLID: led_d = 1'b0;
      LED_FAST:  led_d = ~fast_phase_i;
      default:   led_d = 1'b1;
    endcase
  end

  // Synchroniser, FSM and output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= CH_ABSENT;
      ret_q   <= CH_ABSENT;
      timer_q <= '0;
      mrl_q   <= 1'b0;
      hpd_q   <= 1'b0;
      fault_q <= 1'b0;
      led_q   <= 1'b1;
    end else begin
      sync1_q <= modprsl_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      ret_q   <= ret_d;
      timer_q <= timer_d;
      mrl_q   <= mrl_d;
      hpd_q   <= hpd_d;
      fault_q <= fault_d;
      led_q   <= led_d;
    end
  end

  assign module_resetl_o = mrl_q;
  assign hpd_o           = hpd_q;
  assign fault_o         = fault_q;
  assign led_o           = led_q;

endmodule

// File: rtl/channel_supervisor.sv
// N-channel QSFP/HDMI supervisor: shared blink prescaler, per-channel lanes, power LED.
// Optional CHANNEL_SUPERVISOR_RETRY_EN enables automatic module re-reset on persisting FAULT.
module channel_supervisor
  import channel_supervisor_pkg::*;
#(
  parameter int CHANNEL_COUNT      = 2,
  parameter int CLOCK_FREQUENCY    = 200_000_000,
  parameter int DEBOUNCE_CYCLES    = 2_000_000,
  parameter int RESET_HOLD_CYCLES  = 20_000_000,
  parameter int RUN_TIMEOUT_CYCLES = 400_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNEL_COUNT-1:0] modprsl,
  input  logic [CHANNEL_COUNT-1:0] run,
  output logic [CHANNEL_COUNT-1:0] module_resetl,
  output logic [CHANNEL_COUNT-1:0] hpd,
  output logic [CHANNEL_COUNT-1:0] fault,
  output logic [CHANNEL_COUNT:0]   led
);

  localparam int SLOW_HALF = CLOCK_FREQUENCY / 2;
  localparam int FAST_HALF = (CLOCK_FREQUENCY / 8 > 0) ? CLOCK_FREQUENCY / 8 : 1;
  localparam int PW        = ($clog2(SLOW_HALF) > 0) ? $clog2(SLOW_HALF) : 1;
  localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_HALF - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_HALF - 1);

  logic [PW-1:0]            slow_cnt_q, fast_cnt_q;
  logic                     slow_phase_q, fast_phase_q;
  logic                     led_pwr_q;
  logic [CHANNEL_COUNT-1:0] lane_led_s;

  // Shared prescaler keeps all channel LEDs blinking in phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      slow_cnt_q   <= '0;
      fast_cnt_q   <= '0;
      slow_phase_q <= 1'b0;
      fast_phase_q <= 1'b0;
    end else begin
      if (slow_cnt_q == SLOW_LAST) begin
        slow_cnt_q   <= '0;
        slow_phase_q <= ~slow_phase_q;
      end else begin
        slow_cnt_q   <= slow_cnt_q + PW'(1);
      end
      if (fast_cnt_q == FAST_LAST) begin
        fast_cnt_q   <= '0;
        fast_phase_q <= ~fast_phase_q;
      end else begin
        fast_cnt_q   <= fast_cnt_q + PW'(1);
      end
    end
  end

  // Power LED is lit (low) whenever the block is out of reset.
  always_ff @(posedge clock) begin
    led_pwr_q <= reset;
  end

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_lane
    channel_supervisor_lane #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .RESET_HOLD_CYCLES (RESET_HOLD_CYCLES),
      .RUN_TIMEOUT_CYCLES(RUN_TIMEOUT_CYCLES)
    ) u_lane (
      .clock_i        (clock),
      .reset_i        (reset),
      .modprsl_i      (modprsl[g]),
      .run_i          (run[g]),
      .slow_phase_i   (slow_phase_q),
      .fast_phase_i   (fast_phase_q),
      .module_resetl_o(module_resetl[g]),
      .hpd_o          (hpd[g]),
      .fault_o        (fault[g]),
      .led_o          (lane_led_s[g])
    );
  end

  assign led = {led_pwr_q, lane_led_s};

endmodule

// File: tb/tb_channel_supervisor.sv
// Directed plus randomized bench for channel_supervisor against a behavioural channel model.
module tb_channel_supervisor;

  localparam int NCH = 2;
  localparam int DEB = 4;
  localparam int HOLD = 8;
  localparam int RTO = 16;
  localparam int FREQ = 16;
`ifdef CHANNEL_SUPERVISOR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  // model phases of a channel's life
  localparam int M_OUT = 0, M_ARRIVING = 1, M_POWERUP = 2, M_UP = 3, M_STALLED = 4, M_LEAVING = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] modprsl = '1;
  logic [NCH-1:0] run = '0;
  logic [NCH-1:0] module_resetl, hpd, fault;
  logic [NCH:0]   led;

  int n_cmp = 0;
  int n_bad = 0;

  int md[NCH], nt[NCH], back[NCH], s1[NCH], s2[NCH];
  int kprev;
  logic [NCH-1:0] exp_mrl, exp_hpd, exp_fault;
  logic [NCH:0]   exp_led;

  channel_supervisor #(
    .CHANNEL_COUNT     (NCH),
    .CLOCK_FREQUENCY   (FREQ),
    .DEBOUNCE_CYCLES   (DEB),
    .RESET_HOLD_CYCLES (HOLD),
    .RUN_TIMEOUT_CYCLES(RTO)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .modprsl      (modprsl),
    .run          (run),
    .module_resetl(module_resetl),
    .hpd          (hpd),
    .fault        (fault),
    .led          (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural update for one clock edge, using inputs as they stood before the edge.
  task automatic model_edge();
    int slow, fast, p, r;
    bit up;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        md[c] = M_OUT; nt[c] = 0; back[c] = M_OUT; s1[c] = 1; s2[c] = 1;
      end
      kprev = 0;
      exp_mrl = '0; exp_hpd = '0; exp_fault = '0; exp_led = '1;
    end else begin
      slow = (kprev / (FREQ / 2)) % 2;
      fast = (kprev / (FREQ / 8)) % 2;
      for (int c = 0; c < NCH; c++) begin
        p = (s2[c] == 0) ? 1 : 0;
        s2[c] = s1[c];
        s1[c] = int'(modprsl[c]);
        r = int'(run[c]);
        if (md[c] != M_OUT && md[c] != M_ARRIVING && md[c] != M_LEAVING && p == 0) begin
          back[c] = md[c]; md[c] = M_LEAVING; nt[c] = 0;
        end else begin
          case (md[c])
            M_OUT: if (p == 1) begin md[c] = M_ARRIVING; nt[c] = 0; end
            M_ARRIVING: begin
              if (p == 0) begin md[c] = M_OUT; nt[c] = 0; end
              else begin nt[c]++; if (nt[c] == DEB) begin md[c] = M_POWERUP; nt[c] = 0; end end
            end
            M_POWERUP: begin
              nt[c]++; if (nt[c] == HOLD) begin md[c] = M_UP; nt[c] = 0; end
            end
            M_UP: begin
              if (r == 1) nt[c] = 0;
              else begin nt[c]++; if (nt[c] == RTO) begin md[c] = M_STALLED; nt[c] = 0; end end
            end
            M_STALLED: begin
              if (r == 1) begin md[c] = M_UP; nt[c] = 0; end
              else begin nt[c]++; if (RETRY && nt[c] == RTO) begin md[c] = M_POWERUP; nt[c] = 0; end end
            end
            M_LEAVING: begin
              if (p == 1) begin md[c] = back[c]; nt[c] = 0; end
              else begin nt[c]++; if (nt[c] == DEB) begin md[c] = M_OUT; nt[c] = 0; end end
            end
            default: md[c] = M_OUT;
          endcase
        end
        up = (md[c] == M_UP) || (md[c] == M_STALLED) ||
             (md[c] == M_LEAVING && (back[c] == M_UP || back[c] == M_STALLED));
        exp_mrl[c]   = up;
        exp_hpd[c]   = up;
        exp_fault[c] = (md[c] == M_STALLED);
        if (md[c] == M_POWERUP || (md[c] == M_UP && r == 0)) exp_led[c] = ~slow[0];
        else if (md[c] == M_UP) exp_led[c] = 1'b0;
        else if (md[c] == M_STALLED) exp_led[c] = ~fast[0];
        else exp_led[c] = 1'b1;
      end
      exp_led[NCH] = 1'b0;
      kprev++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("module_resetl", {6'b0, module_resetl}, {6'b0, exp_mrl});
    chk("hpd", {6'b0, hpd}, {6'b0, exp_hpd});
    chk("fault", {6'b0, fault}, {6'b0, exp_fault});
    chk("led", {5'b0, led}, {5'b0, exp_led});
  endtask

  initial begin
    // reset
    for (int i = 0; i < 3; i++) step();
    chk("rst_led", {5'b0, led}, 8'h07);
    chk("rst_hpd", {6'b0, hpd}, 8'h00);
    reset = 1'b0;
    step();
    chk("rel_led", {5'b0, led}, 8'h03);
    chk("rel_mrl", {6'b0, module_resetl}, 8'h00);

    // insertion on ch0, 3-cycle glitch on ch1, then run timeout on ch0
    modprsl = 2'b00;
    for (int i = 0; i <= 30; i++) begin
      step();
      if (i == 2) modprsl[1] = 1'b1;
      chk("ins_hpd0", {7'b0, hpd[0]}, (i >= 14) ? 8'd1 : 8'd0);
      chk("ins_mrl0", {7'b0, module_resetl[0]}, (i >= 14) ? 8'd1 : 8'd0);
      chk("glitch_mrl1", {7'b0, module_resetl[1]}, 8'd0);
      chk("to_fault0", {7'b0, fault[0]}, (i >= 30) ? 8'd1 : 8'd0);
    end
    run[0] = 1'b1;
    step();
    chk("fault_clear", {7'b0, fault[0]}, 8'd0);
    for (int i = 0; i < 3; i++) step();

    // fault persistence with or without retry
    run[0] = 1'b0;
    for (int j = 1; j <= 44; j++) begin
      step();
      if (j == 16) chk("fault_set", {7'b0, fault[0]}, 8'd1);
      if (j == 32) chk("retry_hpd", {7'b0, hpd[0]}, RETRY ? 8'd0 : 8'd1);
      if (j == 40) chk("retry_back", {7'b0, hpd[0]}, 8'd1);
    end
    run[0] = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // short removal glitch is filtered
    modprsl[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 1) modprsl[0] = 1'b0;
      chk("rm_glitch_hpd0", {7'b0, hpd[0]}, 8'd1);
    end

    // sustained removal
    modprsl[0] = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      step();
      chk("rm_hpd0", {7'b0, hpd[0]}, (i < 6) ? 8'd1 : 8'd0);
    end

    // randomized traffic
    modprsl = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) modprsl[c] = ~modprsl[c];
        if ($urandom_range(0, 19) == 0) run[c] = ~run[c];
      end
      step();
    end

    // reset mid-operation
    reset = 1'b1;
    step();
    chk("midrst_led", {5'b0, led}, 8'h07);
    chk("midrst_hpd", {6'b0, hpd}, 8'h00);
    chk("midrst_fault", {6'b0, fault}, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
